// File: rtl/usart_ack_tx_if.sv
// Acknowledge transmitter bus: frame-accepted strobe and captured
// configuration fields in, serial line and status strobes out.
interface usart_ack_tx_if;
    logic        received_done;
    logic [23:0] D;
    logic [1:0]  Adress;
    logic [5:0]  Mod_SEL;
    logic        uart_txd;
    logic        tx_busy;
    logic        ack_done;

    // Receive stage / test driver side
    modport master (
        output received_done, D, Adress, Mod_SEL,
        input  uart_txd, tx_busy, ack_done
    );

    // Transmitter side
    modport slave (
        input  received_done, D, Adress, Mod_SEL,
        output uart_txd, tx_busy, ack_done
    );
endinterface

// File: rtl/usart_ack_tx.sv
// usart_ack_tx: sends a 9-byte 8N1 acknowledge frame
//   FF, addr, mode, D[23:16], D[15:8], D[7:0], STATUS, CHK, AA
// on every rising edge of received_done. One extra trigger can wait in a
// pending buffer while a frame is on the line; further triggers are dropped
// and flagged through the sticky overrun bit carried in STATUS.
// Optional feature macro: USART_ACK_CHKSUM_EN (CHK = XOR of bytes 2..7,
// otherwise CHK is constant 00).
module usart_ack_tx #(
    parameter logic [15:0] BPS_CNT = 16'd434
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    usart_ack_tx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [3:0]  byte_q, byte_d;

    logic        rd_samp_q, rd_samp_d;
    logic        rd_prev_q, rd_prev_d;

    logic [1:0]  fr_adr_q, fr_adr_d;
    logic [5:0]  fr_mod_q, fr_mod_d;
    logic [23:0] fr_dat_q, fr_dat_d;
    logic        fr_sts_q, fr_sts_d;

    logic        pend_vld_q, pend_vld_d;
    logic [1:0]  pend_adr_q, pend_adr_d;
    logic [5:0]  pend_mod_q, pend_mod_d;
    logic [23:0] pend_dat_q, pend_dat_d;

    logic        ovr_q, ovr_d;

    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;

    logic        trig;
    logic        bit_end;
    logic [2:0]  bit_nxt;
    logic [7:0]  cur_byte;
    logic [7:0]  chk_byte;

    // The strobe is registered first, so a trigger seen at one edge is acted on at the next
    assign trig    = rd_samp_q & ~rd_prev_q;
    assign bit_end = (cnt_q == BPS_CNT - 16'd1);
    assign bit_nxt = bit_q + 3'd1;

`ifdef USART_ACK_CHKSUM_EN
    assign chk_byte = {6'b0, fr_adr_q} ^ {2'b0, fr_mod_q} ^ fr_dat_q[23:16]
                    ^ fr_dat_q[15:8] ^ fr_dat_q[7:0] ^ {7'b0, fr_sts_q};
`else
    assign chk_byte = 8'h00;
`endif

    // Select the byte currently being shifted from the latched frame fields
    always_comb begin
        cur_byte = 8'hAA;
        case (byte_q)
            4'd0:    cur_byte = 8'hFF;
            4'd1:    cur_byte = {6'b0, fr_adr_q};
            4'd2:    cur_byte = {2'b0, fr_mod_q};
            4'd3:    cur_byte = fr_dat_q[23:16];
            4'd4:    cur_byte = fr_dat_q[15:8];
            4'd5:    cur_byte = fr_dat_q[7:0];
            4'd6:    cur_byte = {7'b0, fr_sts_q};
            4'd7:    cur_byte = chk_byte;
            default: cur_byte = 8'hAA;
        endcase
    end

    // Next-state logic: frame sequencing, pending buffer and overrun flag
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        rd_samp_d  = bus.received_done;
        rd_prev_d  = rd_samp_q;
        fr_adr_d   = fr_adr_q;
        fr_mod_d   = fr_mod_q;
        fr_dat_d   = fr_dat_q;
        fr_sts_d   = fr_sts_q;
        pend_vld_d = pend_vld_q;
        pend_adr_d = pend_adr_q;
        pend_mod_d = pend_mod_q;
        pend_dat_d = pend_dat_q;
        ovr_d      = ovr_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;

        if (state_q == IDLE || bit_end) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (pend_vld_q || trig) begin
                    state_d  = START;
                    bit_d    = 3'd0;
                    byte_d   = 4'd0;
                    txd_d    = 1'b0;
                    busy_d   = 1'b1;
                    // STATUS reflects any drop since the previous load; loading consumes it
                    fr_sts_d = ovr_q;
                    ovr_d    = 1'b0;
                    if (pend_vld_q) begin
                        fr_adr_d   = pend_adr_q;
                        fr_mod_d   = pend_mod_q;
                        fr_dat_d   = pend_dat_q;
                        // A trigger arriving as the pending frame launches refills the slot
                        pend_vld_d = trig;
                        if (trig) begin
                            pend_adr_d = bus.Adress;
                            pend_mod_d = bus.Mod_SEL;
                            pend_dat_d = bus.D;
                        end
                    end else begin
                        fr_adr_d = bus.Adress;
                        fr_mod_d = bus.Mod_SEL;
                        fr_dat_d = bus.D;
                    end
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    txd_d   = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        txd_d = cur_byte[bit_nxt];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_q == 4'd8) begin
                        state_d = IDLE;
                        byte_d  = 4'd0;
                        busy_d  = 1'b0;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = START;
                        byte_d  = byte_q + 4'd1;
                        txd_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Triggers while a frame is on the line go to the pending slot or are dropped
        if (state_q != IDLE && trig) begin
            if (!pend_vld_q) begin
                pend_vld_d = 1'b1;
                pend_adr_d = bus.Adress;
                pend_mod_d = bus.Mod_SEL;
                pend_dat_d = bus.D;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State register with registered outputs; reset aborts any frame in flight
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            bit_q      <= 3'd0;
            byte_q     <= 4'd0;
            rd_samp_q  <= 1'b0;
            rd_prev_q  <= 1'b0;
            fr_adr_q   <= 2'd0;
            fr_mod_q   <= 6'd0;
            fr_dat_q   <= 24'd0;
            fr_sts_q   <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_adr_q <= 2'd0;
            pend_mod_q <= 6'd0;
            pend_dat_q <= 24'd0;
            ovr_q      <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            rd_samp_q  <= rd_samp_d;
            rd_prev_q  <= rd_prev_d;
            fr_adr_q   <= fr_adr_d;
            fr_mod_q   <= fr_mod_d;
            fr_dat_q   <= fr_dat_d;
            fr_sts_q   <= fr_sts_d;
            pend_vld_q <= pend_vld_d;
            pend_adr_q <= pend_adr_d;
            pend_mod_q <= pend_mod_d;
            pend_dat_q <= pend_dat_d;
            ovr_q      <= ovr_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    assign bus.uart_txd = txd_q;
    assign bus.tx_busy  = busy_q;
    assign bus.ack_done = ack_q;

endmodule

// File: tb/tb_usart_ack_tx.sv
// Testbench for usart_ack_tx (BPS_CNT = 4). Line activity is logged per
// cycle; a timing/frame model built from the acknowledge rules predicts
// where each frame starts and what it carries, and the log is decoded
// against it after each scenario.
module tb_usart_ack_tx;

    localparam int B    = 4;
    localparam int FB   = 90 * B;
    localparam int LOGN = 65536;

`ifdef USART_ACK_CHKSUM_EN
    localparam logic [7:0] EXP_CHK29 = 8'h74;
`else
    localparam logic [7:0] EXP_CHK29 = 8'h00;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    usart_ack_tx_if bus_if ();

    usart_ack_tx #(.BPS_CNT(16'd4)) dut (
        .sys_clk (clk),
        .sys_rst (rst_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          start;
        logic [1:0]  a;
        logic [5:0]  m;
        logic [23:0] d;
    } frame_t;

    frame_t frames[$];
    int     drops[$];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int base  = 0;

    bit txd_log  [LOGN];
    bit busy_log [LOGN];
    bit ack_log  [LOGN];

    // Cycle counter and per-cycle log, sampled 1 time unit after each edge
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (cyc < LOGN) begin
                txd_log[cyc]  = bus_if.uart_txd;
                busy_log[cyc] = bus_if.tx_busy;
                ack_log[cyc]  = bus_if.ack_done;
            end
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: e is the edge at which the transmitter acts on the trigger
    task automatic model_trigger(input int e, input logic [1:0] a, input logic [5:0] m,
                                 input logic [23:0] d);
        frame_t f;
        int     n;
        n   = frames.size();
        f.a = a;
        f.m = m;
        f.d = d;
        if (n > 0 && frames[n-1].start > e) begin
            drops.push_back(e);
            $display("trigger @%0d dropped (pending slot full)", e);
        end else begin
            if (n == 0 || e > frames[n-1].start + FB)
                f.start = e;
            else
                f.start = frames[n-1].start + FB + 1;
            frames.push_back(f);
        end
    endtask

    task automatic fire(input logic [1:0] a, input logic [5:0] m, input logic [23:0] d,
                        input int hold);
        int          t;
        logic [31:0] r;
        @(negedge clk);
        bus_if.Adress        = a;
        bus_if.Mod_SEL       = m;
        bus_if.D             = d;
        bus_if.received_done = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        @(negedge clk);
        if (hold == 0) bus_if.received_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        r = $urandom;
        bus_if.Adress  = r[1:0];
        bus_if.Mod_SEL = r[7:2];
        bus_if.D       = r[31:8];
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            bus_if.received_done = 1'b0;
        end
        model_trigger(t + 1, a, m, d);
    endtask

    task automatic fire_rand(input int hold);
        logic [31:0] r;
        logic [31:0] s;
        r = $urandom;
        s = $urandom;
        fire(r[1:0], r[7:2], {r[31:24], s[15:0]}, hold);
    endtask

    function automatic int last_start();
        return frames[frames.size()-1].start;
    endfunction

    function automatic logic [7:0] exp_byte(input frame_t f, input bit sts, input int idx);
        logic [7:0] x;
        x = 8'h00;
        case (idx)
            0: return 8'hFF;
            1: return {6'b0, f.a};
            2: return {2'b0, f.m};
            3: return f.d[23:16];
            4: return f.d[15:8];
            5: return f.d[7:0];
            6: return {7'b0, sts};
            7: begin
`ifdef USART_ACK_CHKSUM_EN
                x = {6'b0, f.a} ^ {2'b0, f.m} ^ f.d[23:16] ^ f.d[15:8] ^ f.d[7:0] ^ {7'b0, sts};
`endif
                return x;
            end
            default: return 8'hAA;
        endcase
    endfunction

    // Mid-bit samples of one 10-bit symbol: bit0 start, bits 8:1 data LSB first, bit9 stop
    function automatic logic [9:0] decode_sym(input int s, input int idx);
        logic [9:0] sym;
        for (int n = 0; n < 10; n++) sym[n] = txd_log[s + (idx * 10 + n) * B + B / 2];
        return sym;
    endfunction

    task automatic analyze(input int from, input int to);
        int          acks, lows, busys, exp_lows, prev_s, s, a;
        bit          sts;
        logic [9:0]  sym;
        logic [7:0]  eb;
        logic [71:0] seen;
        acks  = 0;
        lows  = 0;
        busys = 0;
        for (int c = from; c <= to; c++) begin
            if (ack_log[c])  acks++;
            if (!txd_log[c]) lows++;
            if (busy_log[c]) busys++;
        end
        chk("ack_count", acks, frames.size());
        chk("busy_cycles", busys, frames.size() * FB);
        exp_lows = 0;
        prev_s   = -1;
        foreach (frames[i]) begin
            s   = frames[i].start;
            a   = s + FB;
            sts = 1'b0;
            foreach (drops[j]) if (drops[j] > prev_s && drops[j] < s) sts = 1'b1;
            chk("start_edge", {txd_log[s-1], txd_log[s]}, 2'b10);
            chk("busy_rise", {busy_log[s-1], busy_log[s]}, 2'b01);
            for (int b = 0; b < 9; b++) begin
                eb  = exp_byte(frames[i], sts, b);
                sym = decode_sym(s, b);
                seen[71 - b*8 -: 8] = sym[8:1];
                chk($sformatf("byte%0d", b), sym, {1'b1, eb, 1'b0});
                exp_lows += (1 + 8 - $countones(eb)) * B;
            end
            chk("ack_pulse", {ack_log[a-1], ack_log[a], ack_log[a+1]}, 3'b010);
            chk("busy_fall", {busy_log[a-1], busy_log[a]}, 2'b10);
            $display("frame start=%0d ack=%0d bytes=%h status=%0d", s, a, seen, sts);
            prev_s = s;
        end
        chk("low_cycles", lows, exp_lows);
        chk("end_idle", {txd_log[to], busy_log[to]}, 2'b10);
    endtask

    task automatic settle();
        if (frames.size() > 0) wait_until(last_start() + FB + 8);
        else                   wait_until(cyc + 8);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_txd", bus_if.uart_txd, 1'b1);
        chk("rst_busy", bus_if.tx_busy, 1'b0);
        chk("rst_ack", bus_if.ack_done, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        frames.delete();
        drops.delete();
        base = cyc + 1;
    endtask

    initial begin
        int s, a, acks, n, gap;
        bus_if.received_done = 1'b0;
        bus_if.D             = 24'd0;
        bus_if.Adress        = 2'd0;
        bus_if.Mod_SEL       = 6'd0;
        repeat (3) @(negedge clk);

        // Idle line after reset
        do_reset();
        wait_until(base + 1000);
        analyze(base, cyc);
        $display("idle: 1000 cycles observed");

        // Single known frame
        do_reset();
        fire(2'd1, 6'h05, 24'h123456, 0);
        s = last_start();
        settle();
        chk("req029_chk", decode_sym(s, 7), {1'b1, EXP_CHK29, 1'b0});
        analyze(base, cyc);

        // Second trigger 100 cycles into a frame
        do_reset();
        fire_rand(0);
        wait_until(last_start() + 100);
        fire(2'd2, 6'h2A, 24'hABCDEF, 0);
        settle();
        analyze(base, cyc);

        // Three triggers in one frame, then a fresh one
        do_reset();
        fire_rand(0);
        s = last_start();
        wait_until(s + 50);
        fire_rand(0);
        wait_until(s + 150);
        fire_rand(0);
        settle();
        fire_rand(0);
        settle();
        analyze(base, cyc);

        // Triggers landing around the ack_done edge
        for (int off = -2; off <= 2; off++) begin
            do_reset();
            fire_rand(0);
            a = last_start() + FB;
            wait_until(a + off - 1);
            fire_rand(0);
            settle();
            analyze(base, cyc);
        end

        // Reset mid-frame aborts without ack_done
        do_reset();
        fire_rand(0);
        s = last_start();
        wait_until(s + 150);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_txd", bus_if.uart_txd, 1'b1);
        chk("abort_busy", bus_if.tx_busy, 1'b0);
        wait_until(s + FB + 20);
        acks = 0;
        for (int c = s; c <= cyc; c++) if (ack_log[c]) acks++;
        chk("abort_no_ack", acks, 0);
        @(negedge clk);
        rst_n = 1'b1;
        frames.delete();
        drops.delete();
        base = cyc + 1;
        wait_until(base + 10);
        fire_rand(0);
        settle();
        analyze(base, cyc);

        // received_done held high for 500 cycles
        do_reset();
        fire_rand(500);
        settle();
        wait_until(cyc + 20);
        analyze(base, cyc);

        // Randomised trigger bursts
        for (int it = 0; it < 8; it++) begin
            do_reset();
            n = 1 + $urandom_range(0, 4);
            for (int k = 0; k < n; k++) begin
                gap = $urandom_range(0, 450);
                wait_until(cyc + gap);
                fire_rand(($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0);
            end
            settle();
            analyze(base, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usart_ack_tx.md
USART_ACK_TX -- requirements
Module: usart_ack_tx

Interface
REQ-001 SHALL have parameter BPS_CNT, default 16'd434, meaning sys_clk cycles per UART bit (50 MHz / 115200).
REQ-002 SHALL have port sys_clk, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port sys_rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port received_done, input, 1, frame-accepted strobe from the receive stage; its rising edge triggers an acknowledge.
REQ-005 SHALL have port D, input, 24, configured data word from the receive stage.
REQ-006 SHALL have port Adress, input, 2, configured address.
REQ-007 SHALL have port Mod_SEL, input, 6, configured mode select.
REQ-008 SHALL have port uart_txd, output, 1, serial acknowledge line, 8N1, idle high.
REQ-009 SHALL have port tx_busy, output, 1, high while a frame is being shifted out.
REQ-010 SHALL have port ack_done, output, 1, one-cycle pulse when the last stop bit of a frame completes.

Function
REQ-011 SHALL detect a trigger when received_done is sampled high and its previous registered sample was low.
REQ-012 SHALL capture Adress, Mod_SEL and D on the trigger cycle; later input changes SHALL NOT affect that frame.
REQ-013 SHALL send 9 bytes in order: FF, {6'b0,Adress}, {2'b0,Mod_SEL}, D[23:16], D[15:8], D[7:0], STATUS, CHK, AA.
REQ-014 STATUS SHALL be {7'b0,ovr}; ovr is a sticky flag set when a trigger is dropped (REQ-021) and cleared when a frame carrying ovr=1 is loaded.
REQ-015 Each byte SHALL be one start bit (0), 8 data bits LSB first, one stop bit (1), each exactly BPS_CNT cycles; no idle gap between bytes of a frame.
REQ-016 Frame length SHALL be exactly 90*BPS_CNT cycles from the first start-bit edge to the ack_done cycle.
REQ-017 SHALL use FSM states IDLE -> START -> DATA (8 bits) -> STOP -> START of next byte, or IDLE after byte 9.
REQ-018 Latency: trigger sampled at edge k with FSM in IDLE -> uart_txd low and tx_busy high from edge k+1.
REQ-019 ack_done SHALL pulse on the cycle the byte-9 stop bit ends; tx_busy SHALL fall on the same edge unless a pending frame starts.
REQ-020 A trigger while busy SHALL be held in a one-deep pending buffer (captured fields); the pending frame SHALL start on the edge after ack_done.
REQ-021 A trigger while busy with the pending buffer full SHALL be dropped and SHALL set ovr.
REQ-022 A trigger in the same cycle as ack_done with no pending frame SHALL be accepted as pending and start on the next edge.
REQ-023 Bit counter SHALL count 0..BPS_CNT-1 and wrap; byte index SHALL count 0..8 and never wrap past 8 mid-frame.

Reset
REQ-024 On sys_rst low, asynchronously: uart_txd=1, tx_busy=0, ack_done=0, FSM=IDLE, counters=0, pending cleared, ovr=0, edge-detect register=0.
REQ-025 Reset mid-frame SHALL abort the frame with no ack_done; after release the block SHALL wait for a new trigger.

Configuration
REQ-026 With macro USART_ACK_CHKSUM_EN defined, CHK SHALL be the XOR of bytes 2 through 7.
REQ-027 Without USART_ACK_CHKSUM_EN, CHK SHALL be 8'h00 and no XOR logic shall be built.

Verification (bench BPS_CNT=4)
REQ-028 Reset, no trigger for 1000 cycles -> uart_txd constant 1, tx_busy 0, ack_done never pulses.
REQ-029 D=24'h123456, Adress=1, Mod_SEL=6'h05, one trigger -> bytes FF 01 05 12 34 56 00 74 AA (CHK 00 without macro), ack_done exactly 360 cycles after the start edge.
REQ-030 Second trigger 100 cycles into frame with D=24'hABCDEF -> second frame starts the edge after ack_done, carries AB CD EF, STATUS 00.
REQ-031 Three triggers within one frame -> third dropped; second frame STATUS=01; third frame (after a fresh trigger) STATUS=00.
REQ-032 Assert sys_rst low 150 cycles into a frame -> uart_txd 1 immediately, no ack_done; new trigger after release yields a complete correct frame.
REQ-033 received_done held high 500 cycles -> exactly one frame sent.
